lfsr_req_arbiter: RTL

Round-robin scheduler that shares one pseudo-random LFSR generator among NREQ requesters. Each requester presents an 8-bit tap mask and an 8-bit sequence count. The block grants one requester at a time, loads its operands into the generator, and issues a start pulse. It then tracks the generator's busy handshake, returns the final LFSR value and pulses that requester's done line. It sits between the user-project I/O logic and the generator instance.

---
 rtl/lfsr_req_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/lfsr_req_arbiter.sv
// Round-robin arbiter sharing one LFSR generator among NREQ requesters.
// Optional watchdog abort enabled by defining ARB_TIMEOUT_EN.
module lfsr_req_arbiter #(
   parameter int NREQ      = 4,
   parameter int DWIDTH    = 8,
   parameter int TO_CYCLES = 1023
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*DWIDTH-1:0]   req_taps,
   input  logic [NREQ*DWIDTH-1:0]   req_seq,
   output logic [NREQ-1:0]          grant,
   output logic [NREQ-1:0]          done,
   output logic [DWIDTH-1:0]        result,
   output logic                     arb_busy,
   output logic                     err,
   output logic                     gen_start,
   output logic [DWIDTH-1:0]        gen_sw,
   output logic [DWIDTH-1:0]        gen_seq,
   input  logic                     gen_busy,
   input  logic [DWIDTH-1:0]        gen_num
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [2:0] {
      IDLE, ISSUE, WAIT_ACK, WAIT_DONE, RESPOND
   } state_t;

   state_t            state_reg;
   logic [PW-1:0]     ptr_reg;
   logic [PW-1:0]     gidx_reg;
   logic [PW-1:0]     sel_idx;
   logic              sel_valid;
   logic              to_hit;
   logic [DWIDTH-1:0] taps_arr [NREQ];
   logic [DWIDTH-1:0] seq_arr  [NREQ];

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign taps_arr[gi] = req_taps[gi*DWIDTH +: DWIDTH];
         assign seq_arr[gi]  = req_seq[gi*DWIDTH +: DWIDTH];
      end
   endgenerate

   // Scan from ptr+1 upward with wrap; the first set request wins.
   always_comb begin
      logic [PW-1:0] cand;
      sel_valid = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      for (int i = 1; i <= NREQ; i++) begin
         cand = PW'((int'(ptr_reg) + i) % NREQ);
         if (!sel_valid && req[cand]) begin
            sel_valid = 1'b1;
            sel_idx   = cand;
         end
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(TO_CYCLES + 1);
   logic [CW-1:0] to_cnt_reg;

   // Cleared while in ISSUE so it reads zero on the first WAIT_ACK cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         to_cnt_reg <= '0;
      end else if (state_reg == ISSUE) begin
         to_cnt_reg <= '0;
      end else if (state_reg == WAIT_ACK || state_reg == WAIT_DONE) begin
         to_cnt_reg <= to_cnt_reg + CW'(1);
      end
   end

   assign to_hit = (state_reg == WAIT_ACK || state_reg == WAIT_DONE) &&
                   (to_cnt_reg == CW'(TO_CYCLES - 1));
`else
   assign to_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         ptr_reg   <= PW'(NREQ - 1);
         gidx_reg  <= '0;
         grant     <= '0;
         done      <= '0;
         result    <= '0;
         arb_busy  <= 1'b0;
         err       <= 1'b0;
         gen_start <= 1'b0;
         gen_sw    <= '0;
         gen_seq   <= '0;
      end else begin
         gen_start <= 1'b0;
         done      <= '0;
         err       <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (sel_valid) begin
                  grant     <= {{(NREQ-1){1'b0}}, 1'b1} << sel_idx;
                  gidx_reg  <= sel_idx;
                  gen_sw    <= taps_arr[sel_idx];
                  gen_seq   <= seq_arr[sel_idx];
                  arb_busy  <= 1'b1;
                  gen_start <= 1'b1;
                  state_reg <= ISSUE;
               end
            end
            ISSUE: begin
               state_reg <= WAIT_ACK;
            end
            WAIT_ACK: begin
               if (to_hit) begin
                  result    <= '0;
                  done      <= grant;
                  err       <= 1'b1;
                  state_reg <= RESPOND;
               end else if (gen_busy) begin
                  state_reg <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               // A real completion takes precedence over a same-cycle timeout.
               if (!gen_busy) begin
                  result    <= gen_num;
                  done      <= grant;
                  state_reg <= RESPOND;
               end else if (to_hit) begin
                  result    <= '0;
                  done      <= grant;
                  err       <= 1'b1;
                  state_reg <= RESPOND;
               end
            end
            RESPOND: begin
               grant     <= '0;
               arb_busy  <= 1'b0;
               ptr_reg   <= gidx_reg;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule
